// File: rtl/axi4l_submap_bridge.sv
// AXI4-Lite bridge toward a register submap: one write and one read in flight, word-aligned downstream addresses.
// Optional response timeout enabled by defining AXI4L_BRIDGE_TIMEOUT_EN.
module axi4l_submap_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [2:0]                s_arprot,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [1:0]                m_bresp,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                m_arprot,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << LSB) - 1);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("axi4l_submap_bridge: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
        $error("axi4l_submap_bridge: TIMEOUT_CYCLES must be 1..65535");
    end

    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [2:0]            awprot_q, awprot_d, arprot_q, arprot_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
    logic                  wr_out_q, wr_out_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  rd_busy_q, rd_busy_d, m_arvalid_q, m_arvalid_d;
    logic                  rd_out_q, rd_out_d, rvalid_q, rvalid_d;
    logic                  aw_hs, w_hs, ar_hs;
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
    logic [15:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
`endif

    assign s_awready = ~aw_held_q;
    assign s_wready  = ~w_held_q;
    assign s_arready = ~rd_busy_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign m_awvalid = m_awvalid_q;
    assign m_awaddr  = awaddr_q & ADDR_MASK;
    assign m_awprot  = awprot_q;
    assign m_wvalid  = m_wvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = wr_out_q;
    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = araddr_q & ADDR_MASK;
    assign m_arprot  = arprot_q;
    assign m_rready  = rd_out_q;

    assign aw_hs = s_awvalid & ~aw_held_q;
    assign w_hs  = s_wvalid & ~w_held_q;
    assign ar_hs = s_arvalid & ~rd_busy_q;

    always_comb begin
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        awprot_d    = awprot_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        m_awvalid_d = m_awvalid_q;
        m_wvalid_d  = m_wvalid_q;
        wr_out_d    = wr_out_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_awaddr;
            awprot_d  = s_awprot;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
        end
        // Issue exactly once: on the edge where the later of AW/W arrives.
        if ((aw_hs | aw_held_q) & (w_hs | w_held_q) & (aw_hs | w_hs)) begin
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
            wr_out_d    = 1'b1;
        end
        if (m_awvalid_q & m_awready) m_awvalid_d = 1'b0;
        if (m_wvalid_q & m_wready)   m_wvalid_d  = 1'b0;
        if (wr_out_q & m_bvalid) begin
            bresp_d  = m_bresp;
            bvalid_d = 1'b1;
            wr_out_d = 1'b0;
        end
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
        wr_cnt_d = '0;
        if (wr_out_q & ~m_bvalid) begin
            if (wr_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                m_awvalid_d = 1'b0;
                m_wvalid_d  = 1'b0;
                wr_out_d    = 1'b0;
                bvalid_d    = 1'b1;
                bresp_d     = 2'b10;
            end else begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
`endif
        if (bvalid_q & s_bready) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
    end

    always_comb begin
        rd_busy_d   = rd_busy_q;
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        m_arvalid_d = m_arvalid_q;
        rd_out_d    = rd_out_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        if (ar_hs) begin
            rd_busy_d   = 1'b1;
            araddr_d    = s_araddr;
            arprot_d    = s_arprot;
            m_arvalid_d = 1'b1;
            rd_out_d    = 1'b1;
        end
        if (m_arvalid_q & m_arready) m_arvalid_d = 1'b0;
        if (rd_out_q & m_rvalid) begin
            rdata_d  = m_rdata;
            rresp_d  = m_rresp;
            rvalid_d = 1'b1;
            rd_out_d = 1'b0;
        end
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
        rd_cnt_d = '0;
        if (rd_out_q & ~m_rvalid) begin
            if (rd_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                m_arvalid_d = 1'b0;
                rd_out_d    = 1'b0;
                rvalid_d    = 1'b1;
                rdata_d     = '0;
                rresp_d     = 2'b10;
            end else begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
`endif
        if (rvalid_q & s_rready) begin
            rvalid_d  = 1'b0;
            rd_busy_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            awprot_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            wr_out_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rd_busy_q   <= 1'b0;
            araddr_q    <= '0;
            arprot_q    <= '0;
            m_arvalid_q <= 1'b0;
            rd_out_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
`endif
        end else begin
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            awprot_q    <= awprot_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            m_awvalid_q <= m_awvalid_d;
            m_wvalid_q  <= m_wvalid_d;
            wr_out_q    <= wr_out_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rd_busy_q   <= rd_busy_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            m_arvalid_q <= m_arvalid_d;
            rd_out_q    <= rd_out_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
`endif
        end
    end
endmodule
